// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and load/store.
// Define ARB_PERF_CNT_EN to add saturating stall and conflict performance counters.
module mem_port_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BE_W  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_valid,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [BE_W-1:0]  d_be,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_valid,
    output logic             mem_req,
    output logic             mem_we,
    output logic [BE_W-1:0]  mem_be,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_conflict_cnt,
`endif
    output logic             stall
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_d_q, last_d_d;  // 1: data side won the last grant
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [BE_W-1:0]  mem_be_q, mem_be_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic             if_valid_q, if_valid_d;
    logic             d_valid_q, d_valid_d;
    logic             pick_d;

    // Data wins when alone, or when both request and fetch had the last grant.
    assign pick_d = d_req & (~if_req | ~last_d_q);

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_d) begin
                    state_d     = StBusyD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_req) begin
                    state_d     = StBusyI;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            StBusyI: begin
                if (mem_ready) begin
                    state_d    = StResp;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    last_d_d   = 1'b0;
                end
            end
            StBusyD: begin
                if (mem_ready) begin
                    state_d   = StResp;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_valid_d = 1'b1;
                    last_d_d  = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_d_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, conflict_cnt_q;
    logic        conflict;

    assign conflict = (state_q == StIdle) & if_req & d_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (conflict && conflict_cnt_q != 32'hFFFF_FFFF) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = stall_cnt_q;
    assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule
